// File: rtl/p23_trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : p23_trap_sequencer
//  Purpose  : Arbitrates synchronous exceptions against MEI/MSI/MTI and
//             sequences one trap at a time into the CSR exception handler,
//             then hands the trap-vector redirect back to the core.
//  Revision : 1.0 - initial release
// ============================================================================
module p23_trap_sequencer #(
    parameter bit EXC_FIRST  = 1'b1,
    parameter int WAIT_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exc_valid,
    input  logic [3:0]            exc_cause,
    input  logic [31:0]           exc_pc,
    input  logic [31:0]           exc_tval,
    input  logic                  inst_boundary,
    input  logic [31:0]           boundary_pc,
    input  logic [31:0]           mip,
    input  logic [31:0]           mie,
    input  logic [31:0]           mstatus,
    input  logic [1:0]            privilege_mode,
    input  logic                  wfi_active,
    input  logic                  exception_select,
    input  logic [31:0]           exception_next_pc,
    output logic                  exception_event,
    output logic [31:0]           cause,
    output logic [31:0]           pc,
    output logic [31:0]           badaddr,
    output logic                  trap_busy,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ack,
    output logic                  wfi_wake,
    output logic [WAIT_CNT_W-1:0] irq_wait_cycles
);

    typedef logic [1:0] state_t;
    localparam state_t c_idle     = 2'd0;
    localparam state_t c_fire     = 2'd1;
    localparam state_t c_wait_sel = 2'd2;
    localparam state_t c_redirect = 2'd3;

    localparam logic [31:0]           c_irq_mask = 32'h0000_0888;
    localparam logic [WAIT_CNT_W-1:0] c_wait_one = WAIT_CNT_W'(1);

    state_t                r_state;
    logic                  r_event;
    logic [31:0]           r_cause;
    logic [31:0]           r_pc;
    logic [31:0]           r_badaddr;
    logic                  r_redirect_valid;
    logic [31:0]           r_redirect_pc;
    logic [WAIT_CNT_W-1:0] r_wait;
    logic                  r_wait_run;

    logic [31:0] w_pend;
    logic        w_irq_en;
    logic        w_irq_take;
    logic        w_irq_accept;
    logic        w_exc_win;
    logic [3:0]  w_irq_code;
    logic        w_unused;

    assign w_pend       = mip & mie;
    assign w_irq_en     = (privilege_mode != 2'b11) | mstatus[3];
    assign w_irq_take   = w_irq_en & (|(w_pend & c_irq_mask));
    assign w_irq_accept = w_irq_take & inst_boundary;
    assign w_exc_win    = exc_valid & (EXC_FIRST | ~w_irq_accept);
    assign w_irq_code   = w_pend[11] ? 4'd11 : (w_pend[3] ? 4'd3 : 4'd7);
    assign w_unused     = ^{mstatus[31:4], mstatus[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_idle;
            r_event          <= 1'b0;
            r_cause          <= '0;
            r_pc             <= '0;
            r_badaddr        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_wait           <= '0;
            r_wait_run       <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    // A fresh wait episode restarts the count; otherwise count
                    // boundary-less cycles and freeze on accept or withdrawal.
                    if (w_irq_take) begin
                        if (!r_wait_run) begin
                            r_wait <= inst_boundary ? '0 : c_wait_one;
                        end else if (!inst_boundary && !(&r_wait)) begin
                            r_wait <= r_wait + c_wait_one;
                        end
                    end
                    r_wait_run <= w_irq_take & ~inst_boundary;

                    if (w_exc_win) begin
                        r_cause   <= {28'b0, exc_cause};
                        r_pc      <= exc_pc;
                        r_badaddr <= exc_tval;
                        r_event   <= 1'b1;
                        r_state   <= c_fire;
                    end else if (w_irq_accept) begin
                        r_cause   <= {1'b1, 27'b0, w_irq_code};
                        r_pc      <= boundary_pc;
                        r_badaddr <= '0;
                        r_event   <= 1'b1;
                        r_state   <= c_fire;
                    end
                end
                c_fire: begin
                    r_event <= 1'b0;
                    r_state <= c_wait_sel;
                end
                c_wait_sel: begin
                    if (exception_select) begin
                        r_redirect_pc    <= exception_next_pc;
                        r_redirect_valid <= 1'b1;
                        r_state          <= c_redirect;
                    end
                end
                c_redirect: begin
                    if (redirect_ack) begin
                        r_redirect_valid <= 1'b0;
                        r_state          <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign exception_event = r_event;
    assign cause           = r_cause;
    assign pc              = r_pc;
    assign badaddr         = r_badaddr;
    assign trap_busy       = (r_state != c_idle);
    assign redirect_valid  = r_redirect_valid;
    assign redirect_pc     = r_redirect_pc;
    assign irq_wait_cycles = r_wait;
    // WFI wake deliberately ignores the global interrupt enable.
    assign wfi_wake        = wfi_active & (|(w_pend & c_irq_mask));

endmodule
`default_nettype wire

// File: tb/tb_p23_trap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p23_trap_sequencer
//  Purpose  : Self-checking bench for p23_trap_sequencer, both tie-break
//             settings, directed scenarios plus randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_p23_trap_sequencer;

    localparam int c_wait_max = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        inst_boundary;
    logic [31:0] boundary_pc, mip, mie, mstatus;
    logic [1:0]  privilege_mode;
    logic        wfi_active, exception_select, redirect_ack;
    logic [31:0] exception_next_pc;

    logic [1:0]       ev_o, busy_o, rv_o, wake_o;
    logic [1:0][31:0] cause_o, pc_o, bad_o, rpc_o;
    logic [1:0][7:0]  wait_o;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;

    // Reference model state, index 1 = exception-first, index 0 = interrupt-first
    int          m_ph   [2];
    logic        m_ev   [2];
    logic        m_rv   [2];
    logic [31:0] m_cause[2], m_pc[2], m_bad[2], m_rpc[2];
    int          m_wait [2];
    bit          m_run  [2];

    always #5 clk = ~clk;

    p23_trap_sequencer #(.EXC_FIRST(1'b1), .WAIT_CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .inst_boundary(inst_boundary),
        .boundary_pc(boundary_pc), .mip(mip), .mie(mie), .mstatus(mstatus),
        .privilege_mode(privilege_mode), .wfi_active(wfi_active),
        .exception_select(exception_select), .exception_next_pc(exception_next_pc),
        .exception_event(ev_o[1]), .cause(cause_o[1]), .pc(pc_o[1]), .badaddr(bad_o[1]),
        .trap_busy(busy_o[1]), .redirect_valid(rv_o[1]), .redirect_pc(rpc_o[1]),
        .redirect_ack(redirect_ack), .wfi_wake(wake_o[1]), .irq_wait_cycles(wait_o[1])
    );

    p23_trap_sequencer #(.EXC_FIRST(1'b0), .WAIT_CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .inst_boundary(inst_boundary),
        .boundary_pc(boundary_pc), .mip(mip), .mie(mie), .mstatus(mstatus),
        .privilege_mode(privilege_mode), .wfi_active(wfi_active),
        .exception_select(exception_select), .exception_next_pc(exception_next_pc),
        .exception_event(ev_o[0]), .cause(cause_o[0]), .pc(pc_o[0]), .badaddr(bad_o[0]),
        .trap_busy(busy_o[0]), .redirect_valid(rv_o[0]), .redirect_pc(rpc_o[0]),
        .redirect_ack(redirect_ack), .wfi_wake(wake_o[0]), .irq_wait_cycles(wait_o[0])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Trap rules applied directly: pending set, enable, priority, tie-break.
    task automatic model_step();
        logic [31:0] pend;
        bit          take, irq_now;
        int          code;
        pend    = mip & mie;
        take    = ((privilege_mode != 2'b11) || mstatus[3]) && ((pend & 32'h888) != 0);
        irq_now = take && inst_boundary;
        code    = pend[11] ? 11 : (pend[3] ? 3 : 7);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_ph[k] = 0; m_ev[k] = 0; m_rv[k] = 0; m_cause[k] = 0; m_pc[k] = 0;
                m_bad[k] = 0; m_rpc[k] = 0; m_wait[k] = 0; m_run[k] = 0;
            end else if (m_ph[k] == 0) begin
                if (take) begin
                    if (!m_run[k])          m_wait[k] = inst_boundary ? 0 : 1;
                    else if (!inst_boundary) m_wait[k] = (m_wait[k] < c_wait_max) ? m_wait[k] + 1 : c_wait_max;
                end
                m_run[k] = take && !inst_boundary;
                if (exc_valid && (k == 1 || !irq_now)) begin
                    m_cause[k] = 32'(exc_cause); m_pc[k] = exc_pc; m_bad[k] = exc_tval;
                    m_ev[k] = 1; m_ph[k] = 1;
                end else if (irq_now) begin
                    m_cause[k] = 32'h8000_0000 + 32'(code); m_pc[k] = boundary_pc; m_bad[k] = 0;
                    m_ev[k] = 1; m_ph[k] = 1;
                end
            end else if (m_ph[k] == 1) begin
                m_ev[k] = 0; m_ph[k] = 2;
            end else if (m_ph[k] == 2) begin
                if (exception_select) begin m_rpc[k] = exception_next_pc; m_rv[k] = 1; m_ph[k] = 3; end
            end else begin
                if (redirect_ack) begin m_rv[k] = 0; m_ph[k] = 0; end
            end
        end
    endtask

    task automatic check_all();
        bit wake_exp;
        wake_exp = wfi_active && (((mip & mie) & 32'h888) != 0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d_event", k),    64'(ev_o[k]),    64'(m_ev[k]));
            check($sformatf("d%0d_busy", k),     64'(busy_o[k]),  64'(m_ph[k] != 0));
            check($sformatf("d%0d_rvalid", k),   64'(rv_o[k]),    64'(m_rv[k]));
            check($sformatf("d%0d_cause", k),    64'(cause_o[k]), 64'(m_cause[k]));
            check($sformatf("d%0d_pc", k),       64'(pc_o[k]),    64'(m_pc[k]));
            check($sformatf("d%0d_badaddr", k),  64'(bad_o[k]),   64'(m_bad[k]));
            check($sformatf("d%0d_rpc", k),      64'(rpc_o[k]),   64'(m_rpc[k]));
            check($sformatf("d%0d_wait", k),     64'(wait_o[k]),  64'(m_wait[k]));
            check($sformatf("d%0d_wfi_wake", k), 64'(wake_o[k]),  64'(wake_exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (busy_o[1]) busy_cnt++;
        check_all();
    endtask

    task automatic sel_and_ack(input logic [31:0] vec);
        exception_select = 1; exception_next_pc = vec;
        tick();
        exception_select = 0; redirect_ack = 1;
        tick();
        redirect_ack = 0;
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_cause = 0; exc_pc = 0; exc_tval = 0; inst_boundary = 0;
        boundary_pc = 0; mip = 0; mie = 0; mstatus = 0; privilege_mode = 2'b11;
        wfi_active = 0; exception_select = 0; exception_next_pc = 0; redirect_ack = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_ev[k] = 0; m_rv[k] = 0; m_cause[k] = 0; m_pc[k] = 0;
            m_bad[k] = 0; m_rpc[k] = 0; m_wait[k] = 0; m_run[k] = 0;
        end
        @(negedge clk);
        tick();
        tick();
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_rpc",  64'(rpc_o[1]), 64'd0);
        reset = 0;

        // Synchronous exception, redirect accepted one cycle late
        exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        busy_cnt = 0;
        tick();
        exc_valid = 0;
        check("t1_event",   64'(ev_o[1]),    64'd1);
        check("t1_cause",   64'(cause_o[1]), 64'd2);
        check("t1_pc",      64'(pc_o[1]),    64'h100);
        check("t1_badaddr", 64'(bad_o[1]),   64'hDEAD);
        tick();
        check("t1_event_1cyc", 64'(ev_o[1]), 64'd0);
        exception_select = 1; exception_next_pc = 32'h80;
        tick();
        exception_select = 0;
        check("t1_rpc", 64'(rpc_o[1]), 64'h80);
        tick();
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        check("t1_busy_cycles", 64'(busy_cnt), 64'd4);

        // Interrupt priority
        mip = 32'h888; mie = 32'h888; mstatus = 32'h8; inst_boundary = 1; boundary_pc = 32'h200;
        tick();
        check("t2_cause_mei", 64'(cause_o[1]), 64'h8000_000B);
        check("t2_pc",        64'(pc_o[0]),    64'h200);
        check("t2_badaddr",   64'(bad_o[0]),   64'd0);
        tick(); sel_and_ack(32'h80);
        mip = 32'h088;
        tick();
        check("t2_cause_msi", 64'(cause_o[1]), 64'h8000_0003);
        tick(); sel_and_ack(32'h80);

        // Global enable only gates machine mode; WFI wake ignores it
        mip = 32'h080; mie = 32'h080; mstatus = 0; wfi_active = 1;
        tick();
        check("t3_no_event", 64'(ev_o[1]),   64'd0);
        check("t3_wfi_wake", 64'(wake_o[1]), 64'd1);
        privilege_mode = 2'b00;
        tick();
        check("t3_cause_mti_u", 64'(cause_o[1]), 64'h8000_0007);
        tick(); sel_and_ack(32'h80);
        wfi_active = 0;

        // Interrupt wait counter and saturation
        privilege_mode = 2'b11; mstatus = 32'h8; inst_boundary = 0;
        for (int i = 0; i < 5; i++) tick();
        inst_boundary = 1;
        tick();
        inst_boundary = 0;
        check("t4_wait5", 64'(wait_o[1]), 64'd5);
        tick(); sel_and_ack(32'h80);
        for (int i = 0; i < 300; i++) tick();
        check("t4_wait_sat", 64'(wait_o[1]), 64'd255);
        mip = 0;
        tick();

        // Exception vs interrupt tie, exception dropped while busy
        mip = 32'h8; mie = 32'h8; inst_boundary = 1;
        exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h400; exc_tval = 32'hFFFF_FFFF;
        tick();
        check("t5_tie_exc_first", 64'(cause_o[1]), 64'd5);
        check("t5_tie_irq_first", 64'(cause_o[0]), 64'h8000_0003);
        check("t5_tval_passthru", 64'(bad_o[1]),   64'hFFFF_FFFF);
        exc_cause = 4'd6; mip = 0;
        tick();
        exc_valid = 0;
        check("t5_busy_drop", 64'(cause_o[1]), 64'd5);
        sel_and_ack(32'h80);

        // Reset mid-trap and delayed acknowledge
        exc_valid = 1; exc_cause = 4'd9; exc_pc = 32'h300; exc_tval = 32'h55;
        tick();
        exc_valid = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        check("t6_rst_wsel_busy",  64'(busy_o),     64'd0);
        check("t6_rst_wsel_cause", 64'(cause_o[1]), 64'd0);
        exc_valid = 1;
        tick();
        exc_valid = 0;
        tick();
        exception_select = 1; exception_next_pc = 32'h90;
        tick();
        exception_select = 0;
        reset = 1;
        tick();
        reset = 0;
        check("t6_rst_redir_rvalid", 64'(rv_o),     64'd0);
        check("t6_rst_redir_rpc",    64'(rpc_o[1]), 64'd0);
        exc_valid = 1;
        tick();
        exc_valid = 0;
        tick();
        exception_select = 1; exception_next_pc = 32'hA0;
        tick();
        exception_select = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_rvalid_held", 64'(rv_o[1]), 64'd1);
        end
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        check("t6_rvalid_drop", 64'(rv_o[1]), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(63) == 0);
            exc_valid         = ($urandom_range(3) == 0);
            exc_cause         = 4'($urandom);
            exc_pc            = $urandom;
            exc_tval          = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
            inst_boundary     = 1'($urandom);
            boundary_pc       = $urandom;
            mip               = $urandom & 32'h0000_0FFF;
            mie               = ($urandom_range(3) == 0) ? $urandom : 32'h888;
            mstatus           = $urandom;
            privilege_mode    = ($urandom_range(1) == 0) ? 2'b11 : 2'b00;
            wfi_active        = 1'($urandom);
            exception_select  = 1'($urandom);
            exception_next_pc = $urandom;
            redirect_ack      = ($urandom_range(2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
